// File: rtl/crc_serial_enc.sv
// crc_serial_enc: bit-serial systematic CRC encoder.
// Takes MSG_LEN message bits (MSB first) over a valid/ready handshake and
// emits a registered serial codeword: the message bits, then CRC_W check bits.
//
// Ports:
//   i_clk       rising-edge clock
//   i_rst_n     asynchronous active-low reset
//   i_clr       synchronous abort, returns block to IDLE with cleared state
//   i_start     begin a new codeword (sampled in IDLE only)
//   i_data      message bit
//   i_valid     i_data qualifier
//   o_ready     message bit accepted this cycle when i_valid is high
//   o_code      codeword bit, qualified by o_code_vld
//   o_code_vld  o_code valid
//   o_crc_done  one-cycle pulse with the last check bit
//   o_busy      block is not IDLE
module crc_serial_enc #(
  parameter int unsigned      CRC_W   = 4,
  parameter logic [CRC_W-1:0] POLY    = CRC_W'(32'h3),
  parameter int unsigned      MSG_LEN = 3,
  parameter logic [CRC_W-1:0] INIT    = '0
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  input  logic i_start,
  input  logic i_data,
  input  logic i_valid,
  output logic o_ready,
  output logic o_code,
  output logic o_code_vld,
  output logic o_crc_done,
  output logic o_busy
);

  localparam int unsigned CNT_MAX = (MSG_LEN > CRC_W) ? MSG_LEN : CRC_W;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DATA = 2'd1,
    S_CHK  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [CRC_W-1:0]   crc_q, crc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               code_q, code_d;
  logic               code_vld_q, code_vld_d;
  logic               done_q, done_d;
  logic               ready_q, ready_d;
  logic               busy_q, busy_d;
  logic               accept_c;
  logic               fb_c;

  // ready is a pure decode of the registered state, so no input reaches it
  assign accept_c = i_valid & ready_q;
  assign fb_c     = i_data ^ crc_q[CRC_W-1];

  // Next-state, datapath and output computation
  always_comb begin
    state_d    = state_q;
    crc_d      = crc_q;
    cnt_d      = cnt_q;
    code_d     = code_q;
    code_vld_d = 1'b0;
    done_d     = 1'b0;

    if (i_clr) begin
      state_d = S_IDLE;
      crc_d   = '0;
      cnt_d   = '0;
      code_d  = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (i_start) begin
            crc_d   = INIT;
            cnt_d   = '0;
            state_d = S_DATA;
          end
        end
        S_DATA: begin
          if (accept_c) begin
            crc_d      = {crc_q[CRC_W-2:0], 1'b0} ^ (fb_c ? POLY : '0);
            code_d     = i_data;
            code_vld_d = 1'b1;
            if (cnt_q == CNT_W'(MSG_LEN - 1)) begin
              cnt_d   = '0;
              state_d = S_CHK;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
        S_CHK: begin
          code_d     = crc_q[CRC_W-1];
          code_vld_d = 1'b1;
          crc_d      = {crc_q[CRC_W-2:0], 1'b0};
          if (cnt_q == CNT_W'(CRC_W - 1)) begin
            cnt_d   = '0;
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = S_IDLE;
          crc_d   = '0;
          cnt_d   = '0;
        end
      endcase
    end

    ready_d = (state_d == S_DATA);
    busy_d  = (state_d != S_IDLE);
  end

  // State and output registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= S_IDLE;
      crc_q      <= '0;
      cnt_q      <= '0;
      code_q     <= 1'b0;
      code_vld_q <= 1'b0;
      done_q     <= 1'b0;
      ready_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      crc_q      <= crc_d;
      cnt_q      <= cnt_d;
      code_q     <= code_d;
      code_vld_q <= code_vld_d;
      done_q     <= done_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
    end
  end

  assign o_ready    = ready_q;
  assign o_code     = code_q;
  assign o_code_vld = code_vld_q;
  assign o_crc_done = done_q;
  assign o_busy     = busy_q;

endmodule

// File: tb/tb_crc_serial_enc.sv
// Directed bench for crc_serial_enc: default 4-bit CRC, CRC-8/0x07 and
// CRC-16/CCITT (init FFFF) instances sharing data/valid/clear/reset.
module tb_crc_serial_enc;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clr = 1'b0;
  logic data = 1'b0;
  logic valid = 1'b0;
  logic start_a = 1'b0;
  logic start_b = 1'b0;
  logic start_c = 1'b0;

  logic a_ready, a_code, a_vld, a_done, a_busy;
  logic b_ready, b_code, b_vld, b_done, b_busy;
  logic c_ready, c_code, c_vld, c_done, c_busy;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  crc_serial_enc u_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_clr(clr), .i_start(start_a),
    .i_data(data), .i_valid(valid), .o_ready(a_ready), .o_code(a_code),
    .o_code_vld(a_vld), .o_crc_done(a_done), .o_busy(a_busy)
  );

  crc_serial_enc #(.CRC_W(8), .POLY(8'h07), .MSG_LEN(16), .INIT(8'h00)) u_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_clr(clr), .i_start(start_b),
    .i_data(data), .i_valid(valid), .o_ready(b_ready), .o_code(b_code),
    .o_code_vld(b_vld), .o_crc_done(b_done), .o_busy(b_busy)
  );

  crc_serial_enc #(.CRC_W(16), .POLY(16'h1021), .MSG_LEN(72), .INIT(16'hFFFF)) u_c (
    .i_clk(clk), .i_rst_n(rst_n), .i_clr(clr), .i_start(start_c),
    .i_data(data), .i_valid(valid), .o_ready(c_ready), .o_code(c_code),
    .o_code_vld(c_vld), .o_crc_done(c_done), .o_busy(c_busy)
  );

  // Record every valid output bit of instance b with its cycle number
  int   cyc = 0;
  logic bq[$];
  int   bt[$];
  int   bd[$];
  always @(negedge clk) begin
    cyc++;
    if (b_vld) begin
      bq.push_back(b_code);
      bt.push_back(cyc);
    end
    if (b_done) bd.push_back(cyc);
  end

  // Reference CRC: XOR the message bit into the top, shift, reduce
  function automatic logic [31:0] crc_model(input logic [31:0] poly, input logic [31:0] init,
                                            input int w, input logic [127:0] msg, input int len);
    logic [31:0] c, top, mask;
    top  = 32'h1 << (w - 1);
    mask = (top << 1) - 32'h1;
    c    = init;
    for (int i = len - 1; i >= 0; i--) begin
      if (msg[i]) c = c ^ top;
      if ((c & top) != 32'h0) c = (c << 1) ^ poly;
      else c = c << 1;
      c = c & mask;
    end
    return c;
  endfunction

  task automatic test_reset;
    @(negedge clk);
    n_checks++;
    if ({a_ready, a_code, a_vld, a_done, a_busy} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_a: got %b expected 00000", {a_ready, a_code, a_vld, a_done, a_busy});
    end
    n_checks++;
    if ({b_ready, b_vld, b_done, b_busy, c_ready, c_vld, c_done, c_busy} !== 8'b0) begin
      n_fail++;
      $display("FAIL reset_bc: got %b expected 00000000",
               {b_ready, b_vld, b_done, b_busy, c_ready, c_vld, c_done, c_busy});
    end
    rst_n = 1'b1;
  endtask

  // One codeword on the default instance; gap idles between data bits
  task automatic run_a(input string name, input logic [2:0] msg, input logic [6:0] exp,
                       input int gap, input bit hold_start);
    @(negedge clk);
    start_a = 1'b1;
    @(negedge clk);
    start_a = hold_start;
    n_checks++;
    if ({a_ready, a_busy, a_vld} !== 3'b110) begin
      n_fail++;
      $display("FAIL %s_start: got ready/busy/vld %b expected 110", name, {a_ready, a_busy, a_vld});
    end
    for (int b = 0; b < 3; b++) begin
      if (b == 2) start_a = 1'b0;
      data  = msg[2-b];
      valid = 1'b1;
      @(negedge clk);
      valid = 1'b0;
      n_checks++;
      if ({a_vld, a_code, a_done, a_busy} !== {1'b1, exp[6-b], 1'b0, 1'b1}) begin
        n_fail++;
        $display("FAIL %s_data%0d: got vld/code/done/busy %b expected %b", name, b,
                 {a_vld, a_code, a_done, a_busy}, {1'b1, exp[6-b], 1'b0, 1'b1});
      end
      if (b < 2) begin
        for (int g = 0; g < gap; g++) begin
          @(negedge clk);
          n_checks++;
          if ({a_vld, a_code, a_ready} !== {1'b0, exp[6-b], 1'b1}) begin
            n_fail++;
            $display("FAIL %s_gap%0d: got vld/code/ready %b expected %b", name, b,
                     {a_vld, a_code, a_ready}, {1'b0, exp[6-b], 1'b1});
          end
        end
      end
    end
    n_checks++;
    if (a_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_chk_ready: got %b expected 0", name, a_ready);
    end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      n_checks++;
      if ({a_vld, a_code, a_done, a_busy} !== {1'b1, exp[3-c], (c == 3), (c != 3)}) begin
        n_fail++;
        $display("FAIL %s_chk%0d: got vld/code/done/busy %b expected %b", name, c,
                 {a_vld, a_code, a_done, a_busy}, {1'b1, exp[3-c], (c == 3), (c != 3)});
      end
    end
    @(negedge clk);
    n_checks++;
    if ({a_vld, a_done, a_busy} !== 3'b000) begin
      n_fail++;
      $display("FAIL %s_idle: got vld/done/busy %b expected 000", name, {a_vld, a_done, a_busy});
    end
  endtask

  task automatic test_clear;
    @(negedge clk);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    for (int b = 0; b < 2; b++) begin
      data  = 1'b1;
      valid = 1'b1;
      @(negedge clk);
    end
    valid = 1'b0;
    clr   = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    n_checks++;
    if ({a_ready, a_code, a_vld, a_done, a_busy} !== 5'b0) begin
      n_fail++;
      $display("FAIL clear: got %b expected 00000", {a_ready, a_code, a_vld, a_done, a_busy});
    end
    repeat (6) begin
      @(negedge clk);
      n_checks++;
      if ({a_vld, a_done, a_busy} !== 3'b000) begin
        n_fail++;
        $display("FAIL clear_quiet: got vld/done/busy %b expected 000", {a_vld, a_done, a_busy});
      end
    end
    clr     = 1'b1;
    start_a = 1'b1;
    @(negedge clk);
    clr     = 1'b0;
    start_a = 1'b0;
    n_checks++;
    if ({a_ready, a_busy} !== 2'b00) begin
      n_fail++;
      $display("FAIL clr_vs_start: got ready/busy %b expected 00", {a_ready, a_busy});
    end
    run_a("after_clr", 3'b101, 7'b1011111, 0, 1'b0);
  endtask

  task automatic test_async_reset;
    @(negedge clk);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    for (int b = 0; b < 3; b++) begin
      data  = (b != 1);
      valid = 1'b1;
      @(negedge clk);
    end
    valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({a_vld, a_code, a_busy} !== 3'b111) begin
      n_fail++;
      $display("FAIL async_pre: got vld/code/busy %b expected 111", {a_vld, a_code, a_busy});
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({a_ready, a_code, a_vld, a_done, a_busy} !== 5'b0) begin
      n_fail++;
      $display("FAIL async_rst: got %b expected 00000", {a_ready, a_code, a_vld, a_done, a_busy});
    end
    @(negedge clk);
    rst_n = 1'b1;
    n_checks++;
    if ({a_vld, a_done, a_busy} !== 3'b000) begin
      n_fail++;
      $display("FAIL async_hold: got vld/done/busy %b expected 000", {a_vld, a_done, a_busy});
    end
  endtask

  // Three CRC-8 codewords, each start issued in the previous done cycle
  task automatic test_back_to_back;
    logic [15:0] msgs[3];
    logic [15:0] gd;
    logic [7:0]  gc, ec;
    msgs[0] = 16'h0001;
    msgs[1] = 16'($urandom);
    msgs[2] = 16'($urandom);
    bq.delete();
    bt.delete();
    bd.delete();
    @(negedge clk);
    start_b = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      start_b = 1'b0;
      for (int i = 0; i < 16; i++) begin
        data  = msgs[k][15-i];
        valid = 1'b1;
        @(negedge clk);
      end
      valid = 1'b0;
      repeat (8) @(negedge clk);
      n_checks++;
      if ({b_done, b_busy} !== 2'b10) begin
        n_fail++;
        $display("FAIL b2b_done%0d: got done/busy %b expected 10", k, {b_done, b_busy});
      end
      if (k < 2) start_b = 1'b1;
    end
    @(negedge clk);
    n_checks++;
    if (bq.size() != 72 || bd.size() != 3) begin
      n_fail++;
      $display("FAIL b2b_count: got bits %0d dones %0d expected 72 3", bq.size(), bd.size());
    end else begin
      for (int k = 0; k < 3; k++) begin
        for (int j = 0; j < 16; j++) gd[15-j] = bq[k*24+j];
        for (int j = 0; j < 8; j++) gc[7-j] = bq[k*24+16+j];
        ec = 8'(crc_model(32'h07, 32'h0, 8, 128'(msgs[k]), 16));
        n_checks++;
        if ({gd, gc} !== {msgs[k], ec}) begin
          n_fail++;
          $display("FAIL b2b_word%0d: got %h expected %h", k, {gd, gc}, {msgs[k], ec});
        end
        n_checks++;
        if (bt[k*24+23] - bt[k*24] != 23 || bd[k] != bt[k*24+23]) begin
          n_fail++;
          $display("FAIL b2b_contig%0d: got span %0d done@%0d expected span 23 done@%0d", k,
                   bt[k*24+23] - bt[k*24], bd[k], bt[k*24+23]);
        end
        if (k == 0) begin
          n_checks++;
          if (gc !== 8'h07) begin
            n_fail++;
            $display("FAIL crc8_unit: got %h expected 07", gc);
          end
        end else begin
          n_checks++;
          if (bt[k*24] - bt[(k-1)*24] != 25) begin
            n_fail++;
            $display("FAIL b2b_period%0d: got %0d expected 25", k, bt[k*24] - bt[(k-1)*24]);
          end
        end
      end
    end
  endtask

  // CRC-16/CCITT-FALSE over "123456789" has the well-known check value 29B1
  task automatic test_ccitt;
    logic [71:0] msg;
    logic [71:0] gd;
    logic [15:0] gc;
    int          bad;
    msg = 72'h313233343536373839;
    bad = 0;
    @(negedge clk);
    start_c = 1'b1;
    @(negedge clk);
    start_c = 1'b0;
    for (int i = 0; i < 72; i++) begin
      data  = msg[71-i];
      valid = 1'b1;
      @(negedge clk);
      gd[71-i] = c_code;
      if (c_vld !== 1'b1 || c_done !== 1'b0) bad++;
    end
    valid = 1'b0;
    for (int j = 0; j < 16; j++) begin
      @(negedge clk);
      gc[15-j] = c_code;
      if (c_vld !== 1'b1 || c_done !== (j == 15)) bad++;
    end
    n_checks++;
    if (gd !== msg) begin
      n_fail++;
      $display("FAIL ccitt_data: got %h expected %h", gd, msg);
    end
    n_checks++;
    if (gc !== 16'h29B1) begin
      n_fail++;
      $display("FAIL ccitt_crc: got %h expected 29b1", gc);
    end
    n_checks++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL ccitt_flags: got %0d bad vld/done cycles expected 0", bad);
    end
  endtask

  initial begin
    test_reset();
    run_a("msg101", 3'b101, 7'b1011111, 0, 1'b0);
    run_a("msg111", 3'b111, 7'b1111001, 0, 1'b0);
    run_a("msg000", 3'b000, 7'b0000000, 0, 1'b0);
    run_a("gap101", 3'b101, 7'b1011111, 2, 1'b0);
    test_clear();
    test_async_reset();
    run_a("start_in_data", 3'b101, 7'b1011111, 0, 1'b1);
    test_back_to_back();
    test_ccitt();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule

// File: doc/crc_serial_enc.md
# crc_serial_enc

Parametrised serial CRC encoder: accepts a MSG_LEN-bit message one bit at a time under a valid/ready handshake and emits the systematic codeword (message bits, then CRC_W check bits) as a registered serial stream, MSB first. It generalises the team's fixed 4-bit/3-bit serial CRC generator with the following additions:

- selectable polynomial, CRC width, message length and initial value;
- input flow control;
- explicit start and abort controls.

It sits between a bit-serial payload source and the line/channel serialiser.

## Interface
- CRC_W, 4: CRC register width (degree of generator polynomial), 2..32.
- POLY, 4'h3: generator polynomial with the implicit x^CRC_W term omitted (default x^4+x+1).
- MSG_LEN, 3: message bits per codeword, 1..1024.
- INIT, 0: CRC register value loaded on start (CRC_W bits).
- i_clk  in  1  clock, rising edge.
- i_rst_n  in  1  reset. One clock; reset is asynchronous and active-low.
- i_clr  in  1  synchronous abort; highest priority after reset.
- i_start  in  1  start a new codeword; sampled only in IDLE.
- i_data  in  1  message bit, MSB of message first.
- i_valid  in  1  i_data valid.
- o_ready  out  1  block accepts a message bit this cycle.
- o_code  out  1  codeword bit.
- o_code_vld  out  1  o_code valid this cycle.
- o_crc_done  out  1  high with the last CRC bit of a codeword.
- o_busy  out  1  state != IDLE.

## Operation
- Reset (async, i_rst_n=0): state=IDLE, crc=0, cnt=0. o_code, o_code_vld, o_crc_done, o_ready and o_busy are all 0.
- States: IDLE, DATA, CHK.
- IDLE: on i_start=1, load crc<=INIT and cnt<=0, then go to DATA. i_start is ignored in DATA/CHK.
- DATA: o_ready=1, a decode of the registered state with no combinational path from inputs. A bit is accepted when i_valid & o_ready.
  - On acceptance: fb = i_data ^ crc[CRC_W-1]; crc <= {crc[CRC_W-2:0],1'b0} ^ (fb ? POLY : 0).
  - On acceptance: o_code<=i_data, o_code_vld<=1, cnt<=cnt+1.
  - Cycles without acceptance: o_code_vld<=0, crc unchanged.
  - On acceptance of the last message bit (cnt==MSG_LEN-1): cnt<=0 and go to CHK.
- CHK: o_ready=0. Every cycle: o_code<=crc[CRC_W-1], o_code_vld<=1, crc<=crc<<1, cnt<=cnt+1. There is no stall.
  - On the CRC_W-th bit: o_crc_done<=1 and go to IDLE.
- o_crc_done is a one-cycle pulse, coincident with o_code_vld for the final check bit.
- i_clr=1 in any state has the same effect as reset on the next edge. A partial codeword is discarded and o_crc_done is not asserted.
- cnt width is $clog2(max(MSG_LEN,CRC_W)+1). CRC arithmetic is mod-2 only, with no carries.
- o_code holds its last value while o_code_vld=0. Consumers qualify on o_code_vld.

## Timing
- Input-to-output latency: one cycle (accepted bit appears on o_code on the next edge).
- i_start in cycle N: o_ready=1 from cycle N+1.
- Back-to-back i_valid: the codeword is contiguous, MSG_LEN+CRC_W consecutive o_code_vld cycles with no gap between data and check bits. The first CRC bit follows the last data bit on the next cycle.
- Gaps in i_valid produce matching gaps in o_code_vld during DATA only.
- o_busy falls on the same edge that raises o_crc_done. i_start in the o_crc_done cycle is accepted, giving a minimum codeword period of MSG_LEN+CRC_W+1 cycles.
- Simultaneous i_clr and i_start in IDLE: i_clr wins, and the block stays IDLE.
- i_valid while not ready: the bit is ignored, and the source must hold it.

## Test plan
- Defaults, message 101 with i_valid held high: o_code stream is 1,0,1,1,1,1,1 on 7 consecutive vld cycles. o_crc_done is high only on the 7th, and o_busy drops on that same edge.
- Message 111: the stream is 111 1001. Message 000 with INIT=0: the stream is 000 0000.
- Message 101 with i_valid deasserted for 2 cycles between bits: o_code_vld shows matching gaps, the CRC is still 1111, and the check bits are contiguous.
- i_clr asserted after 2 accepted bits: next cycle all outputs 0 and state IDLE, with no o_crc_done. A following i_start/101 gives the correct 1011111.
- Async i_rst_n pulse mid-CHK, not aligned to a clock edge: outputs go to 0 immediately. i_start during DATA is ignored, and the CRC is unchanged.
- Parameter sweep (CRC_W=8, POLY=8'h07, MSG_LEN=16, random messages, plus CRC_W=16, POLY=16'h1021, INIT=16'hFFFF): check bits must match a reference model. Start re-issued in the o_crc_done cycle must produce back-to-back codewords.
